tt_mux4_arb: RTL and testbench

//  - Round-robin arbiter that shares one 1-bit output among 4 requesters.
//  - Drives the select of a tt_prim_mux4 instance, which carries the shared datapath.
//  - Registered grant with a 1-cycle turnaround gap between owners.
//  - Optional tenure timeout forces release when other requesters are waiting.

---
 rtl/tt_mux4_arb_pkg.sv | 38 +++
 rtl/tt_prim_mux4.sv | 29 ++
 rtl/tt_mux4_arb.sv | 130 +++++++++++++
 tb/tb_tt_mux4_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tt_mux4_arb_pkg.sv
// ============================================================================
// Module  : tt_mux4_arb_pkg
// Brief   : Shared state encoding, sizes and round-robin pick for tt_mux4_arb.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package tt_mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Rotate so last+1 sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0]   sh;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   p;
    sh  = last + 2'd1;
    dbl = {r, r} >> sh;
    rot = dbl[N_REQ-1:0];
    p   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) p = SEL_W'(i);
    end
    return p + sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_prim_mux4.sv
// ============================================================================
// Module  : tt_prim_mux4
// Brief   : 4:1 single-bit multiplexer primitive.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tt_prim_mux4 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic [1:0] s,
  output logic       y
);

  always_comb begin
    y = a;
    case (s)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tt_mux4_arb.sv
// ============================================================================
// Module  : tt_mux4_arb
// Brief   : Round-robin 4-way arbiter with registered grant and 1-cycle gap,
//           steering a tt_prim_mux4. Macro TT_MUX4_ARB_TIMEOUT_EN adds a
//           tenure timeout that forces release when others are waiting.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tt_mux4_arb
  import tt_mux4_arb_pkg::*;
#(
  parameter int TENURE_W   = 4,
  parameter int TENURE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy
);

  if (TENURE_MAX < 1 || TENURE_MAX > (2 ** TENURE_W) - 1) begin : g_tenure_range_bad
    $error("tt_mux4_arb: TENURE_MAX out of range for TENURE_W");
  end

  state_t           state, state_nx;
  logic [N_REQ-1:0] gnt_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [SEL_W-1:0] last, last_nx;
  logic [SEL_W-1:0] winner;
  logic             mux_y;

`ifdef TT_MUX4_ARB_TIMEOUT_EN
  logic [TENURE_W-1:0] cnt, cnt_nx;
`endif

  assign winner = rr_pick(req, last);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    sel_nx   = sel;
    last_nx  = last;
`ifdef TT_MUX4_ARB_TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    case (state)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          state_nx         = ST_GRANT;
          gnt_nx           = '0;
          gnt_nx[winner]   = 1'b1;
          sel_nx           = winner;
          last_nx          = winner;
`ifdef TT_MUX4_ARB_TIMEOUT_EN
          cnt_nx           = '0;
`endif
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[sel]) begin
          state_nx = ST_GAP;
          gnt_nx   = '0;
        end
`ifdef TT_MUX4_ARB_TIMEOUT_EN
        // At the tenure limit the owner is only evicted if someone else waits.
        else if (cnt == TENURE_W'(TENURE_MAX - 1)) begin
          cnt_nx = '0;
          if ((req & ~gnt) != '0) begin
            state_nx = ST_GAP;
            gnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= SEL_W'(N_REQ - 1);
`ifdef TT_MUX4_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      sel   <= sel_nx;
      last  <= last_nx;
`ifdef TT_MUX4_ARB_TIMEOUT_EN
      cnt   <= cnt_nx;
`endif
    end
  end

  tt_prim_mux4 u_mux (
    .a (din[0]),
    .b (din[1]),
    .c (din[2]),
    .d (din[3]),
    .s (sel),
    .y (mux_y)
  );

  assign dout_vld = |gnt;
  assign dout     = mux_y & dout_vld;
  assign busy     = (state != ST_IDLE);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt) && ((gnt == '0) || gnt[sel]));

endmodule

`default_nettype wire

// File: tb/tb_tt_mux4_arb.sv
// ============================================================================
// Module  : tb_tt_mux4_arb
// Brief   : Table-driven, scoreboarded bench for tt_mux4_arb.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_tt_mux4_arb;

`ifdef TT_MUX4_ARB_TIMEOUT_EN
  localparam int TMAX = 4;
`else
  localparam int TMAX = 15;
`endif

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dout;
    logic       busy;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] din   = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       dout_vld;
  logic       busy;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   vidx   = 0;
  vec_t e;
  logic [8:0] got;
  logic [8:0] expv;

  tt_mux4_arb #(.TENURE_W(4), .TENURE_MAX(TMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic [1:0] s, input logic o, input logic b);
    vec_t v;
    v = '{req: r, din: d, gnt: g, sel: s, dout: o, busy: b};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    req = v.req;
    din = v.din;
    sb.push_back(v);
  endtask

  // Outputs sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e    = sb.pop_front();
      got  = {gnt, sel, dout_vld, dout, busy};
      expv = {e.gnt, e.sel, |e.gnt, e.dout, e.busy};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL vec%0d {gnt,sel,vld,dout,busy} got=%b required=%b", vidx, got, expv);
      end
      vidx++;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    // Rotation with 2-cycle tenures, re-raise in GAP, datapath gating.
    add(4'hF, 4'h0, 4'b0001, 2'd0, 1'b0, 1'b1);
    add(4'hF, 4'h1, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'hE, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'hF, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'hF, 4'h0, 4'b0010, 2'd1, 1'b0, 1'b1);
    add(4'hD, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b1);
    add(4'hF, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'hF, 4'hB, 4'b0100, 2'd2, 1'b0, 1'b1);
    add(4'hB, 4'hF, 4'b0000, 2'd2, 1'b0, 1'b1);
    add(4'hF, 4'h8, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(4'hF, 4'h7, 4'b1000, 2'd3, 1'b0, 1'b1);
    add(4'h7, 4'h0, 4'b0000, 2'd3, 1'b0, 1'b1);
    add(4'hF, 4'h1, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'h0, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Single requester 2, with a glitch on req[0] that must be ignored.
    add(4'h4, 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1);
    add(4'h4, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'h5, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1);
    add(4'h4, 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1);
    add(4'h4, 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b0);
    // Owner drop and new request in the same cycle still pays the gap.
    add(4'h1, 4'h0, 4'b0001, 2'd0, 1'b0, 1'b1);
    add(4'h2, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'h2, 4'h0, 4'b0010, 2'd1, 1'b0, 1'b1);
    // Lone re-requester in GAP wins again.
    add(4'h0, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b1);
    add(4'h2, 4'h0, 4'b0010, 2'd1, 1'b0, 1'b1);
    add(4'h2, 4'h2, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b0);
`ifdef TT_MUX4_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) add(4'h3, 4'h0, 4'b0001, 2'd0, 1'b0, 1'b1);
    add(4'h3, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(4'h3, 4'h0, 4'b0010, 2'd1, 1'b0, 1'b1);
    add(4'h3, 4'h0, 4'b0000, 2'd1, 1'b0, 1'b1);
    add(4'h3, 4'h0, 4'b0001, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) add(4'h1, 4'h0, 4'b0001, 2'd0, 1'b0, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'h0, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif
    // Set up a grant for the mid-tenure reset.
    add(4'h4, 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1);
    add(4'h4, 4'h0, 4'b0100, 2'd2, 1'b0, 1'b1);

    // Reset held with all requests asserted.
    req = 4'hF;
    din = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, sel, dout_vld, dout, busy} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got=%b required=%b", {gnt, sel, dout_vld, dout, busy}, 9'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    foreach (tbl[i]) drive(tbl[i]);

    // Asynchronous reset mid-tenure.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, sel, dout_vld, dout, busy} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset got=%b required=%b", {gnt, sel, dout_vld, dout, busy}, 9'd0);
    end
    req = 4'hF;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive('{req: 4'hF, din: 4'h1, gnt: 4'b0001, sel: 2'd0, dout: 1'b1, busy: 1'b1});
    drive('{req: 4'hF, din: 4'h0, gnt: 4'b0001, sel: 2'd0, dout: 1'b0, busy: 1'b1});
    @(negedge clk);
    @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
